// File: rtl/time_display_driver.sv
// Binary-to-BCD conversion of a 16-bit count (iterative double-dabble) driving a
// 4-digit multiplexed common-anode 7-segment display with dp, zero blanking and overflow.
module time_display_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DP_POS      = 1
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [15:0] Time,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        overflow,
    output logic        conv_done
);

    localparam int unsigned BIN_W   = 16;
    localparam int unsigned NDIG    = 5;
    localparam int unsigned BCD_W   = 4 * NDIG;
    localparam int unsigned WORK_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [3:0] SHIFT_LAST = 4'(BIN_W - 1);
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WORK_W-1:0]    work_q, work_d;
    logic [BIN_W-1:0]     last_q, last_d;
    logic                 force_q, force_d;
    logic [3:0]           shift_cnt_q, shift_cnt_d;
    logic [BCD_W-1:0]     digits_q, digits_d;
    logic                 overflow_q, overflow_d;
    logic                 conv_done_q, conv_done_d;
    logic [CNT_W-1:0]     refresh_cnt_q, refresh_cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [3:0]           an_q, an_d;

    logic                 start_c;
    logic                 load_c;
    logic                 shift_c;
    logic                 latch_c;
    logic [WORK_W-1:0]    work_adj_c;
    logic [3:0]           digit_c;
    logic                 hi_zero_c;
    logic                 blank_c;
    logic [6:0]           seg_dec_c;

    // A new conversion starts on any change of Time, or once after reset.
    assign start_c = (Time != last_q) || force_q;

    // FSM state register
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_c) state_d = S_SHIFT;
            S_SHIFT: if (shift_cnt_q == SHIFT_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output decode: datapath strobes
    always_comb begin
        load_c  = 1'b0;
        shift_c = 1'b0;
        latch_c = 1'b0;
        case (state_q)
            S_IDLE:  load_c  = start_c;
            S_SHIFT: shift_c = 1'b1;
            S_DONE:  latch_c = 1'b1;
            default: ;
        endcase
    end

    // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift
    always_comb begin
        work_adj_c = work_q;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (work_q[BIN_W + 4*i +: 4] >= 4'd5) begin
                work_adj_c[BIN_W + 4*i +: 4] = work_q[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath next state
    always_comb begin
        work_d      = work_q;
        last_d      = last_q;
        force_d     = force_q;
        shift_cnt_d = shift_cnt_q;
        digits_d    = digits_q;
        overflow_d  = overflow_q;
        conv_done_d = latch_c;
        if (load_c) begin
            work_d      = {{BCD_W{1'b0}}, Time};
            last_d      = Time;
            force_d     = 1'b0;
            shift_cnt_d = 4'd0;
        end
        if (shift_c) begin
            work_d      = {work_adj_c[WORK_W-2:0], 1'b0};
            shift_cnt_d = shift_cnt_q + 4'd1;
        end
        if (latch_c) begin
            digits_d   = work_q[WORK_W-1:BIN_W];
            overflow_d = (work_q[WORK_W-1 -: 4] != 4'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            work_q      <= '0;
            last_q      <= '0;
            force_q     <= 1'b1;
            shift_cnt_q <= 4'd0;
            digits_q    <= '0;
            overflow_q  <= 1'b0;
            conv_done_q <= 1'b0;
        end else begin
            work_q      <= work_d;
            last_q      <= last_d;
            force_q     <= force_d;
            shift_cnt_q <= shift_cnt_d;
            digits_q    <= digits_d;
            overflow_q  <= overflow_d;
            conv_done_q <= conv_done_d;
        end
    end

    // Refresh timebase: each digit stays lit for REFRESH_DIV cycles
    always_comb begin
        refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        if (refresh_cnt_q == CNT_MAX) begin
            refresh_cnt_d = '0;
            idx_d         = idx_q + 2'd1;
        end
    end

    // Digit select and leading-zero detection over the digit and everything above it
    always_comb begin
        digit_c   = digits_q[3:0];
        hi_zero_c = 1'b0;
        case (idx_q)
            2'd0: begin
                digit_c   = digits_q[3:0];
                hi_zero_c = (digits_q == '0);
            end
            2'd1: begin
                digit_c   = digits_q[7:4];
                hi_zero_c = (digits_q[BCD_W-1:4] == '0);
            end
            2'd2: begin
                digit_c   = digits_q[11:8];
                hi_zero_c = (digits_q[BCD_W-1:8] == '0);
            end
            default: begin
                digit_c   = digits_q[15:12];
                hi_zero_c = (digits_q[BCD_W-1:12] == '0);
            end
        endcase
        blank_c = (32'(idx_q) > DP_POS) && hi_zero_c;
    end

    // Active-low {g,f,e,d,c,b,a} decode; non-decimal codes go dark
    always_comb begin
        case (digit_c)
            4'd0:    seg_dec_c = 7'h40;
            4'd1:    seg_dec_c = 7'h79;
            4'd2:    seg_dec_c = 7'h24;
            4'd3:    seg_dec_c = 7'h30;
            4'd4:    seg_dec_c = 7'h19;
            4'd5:    seg_dec_c = 7'h12;
            4'd6:    seg_dec_c = 7'h02;
            4'd7:    seg_dec_c = 7'h78;
            4'd8:    seg_dec_c = 7'h00;
            4'd9:    seg_dec_c = 7'h10;
            default: seg_dec_c = SEG_BLANK;
        endcase
    end

    always_comb begin
        seg_d = blank_c ? SEG_BLANK : seg_dec_c;
        dp_d  = (32'(idx_q) != DP_POS);
        an_d  = ~(4'b0001 << idx_q);
    end

    // Display timebase and pin registers
    always_ff @(posedge clock) begin
        if (rst) begin
            refresh_cnt_q <= '0;
            idx_q         <= 2'd0;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            an_q          <= 4'hF;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            idx_q         <= idx_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign overflow  = overflow_q;
    assign conv_done = conv_done_q;

endmodule

// File: tb/tb_time_display_driver.sv
// Scoreboard bench for time_display_driver: conversion results, latency, display scan,
// overflow and reset-mid-conversion behaviour.
module tb_time_display_driver;

    logic        clk;
    logic        rst;
    logic [15:0] tm;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        overflow;
    logic        conv_done;

    int n_pass  = 0;
    int n_total = 0;

    // Expected {bcd[19:0], overflow} per conversion, oldest first
    logic [20:0] sb[$];

    time_display_driver #(
        .REFRESH_DIV(4),
        .DP_POS     (1)
    ) dut (
        .clock    (clk),
        .rst      (rst),
        .Time     (tm),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .overflow (overflow),
        .conv_done(conv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [19:0] ref_bcd(input int v);
        return {4'(v / 10000), 4'((v / 1000) % 10), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Monitor: every conv_done pulse is checked against the oldest expectation
    always @(negedge clk) begin
        if (!rst && conv_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_conv_done", 32'(conv_done), 32'd0);
            end else begin
                logic [20:0] e;
                e = sb.pop_front();
                chk("bcd", 32'(dut.digits_q), 32'(e[20:1]));
                chk("overflow", 32'(overflow), 32'(e[0]));
            end
        end
    end

    // Count rising edges until conv_done is seen; check against the expected latency
    task automatic wait_done(input int exp_lat);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!conv_done && n < 60);
        if (!conv_done) chk("conv_done_timeout", 32'(n), 32'(exp_lat));
        else            chk("latency", 32'(n), 32'(exp_lat));
    endtask

    task automatic apply(input logic [15:0] v, input logic [19:0] bcd, input logic ovf);
        @(negedge clk);
        tm = v;
        sb.push_back({bcd, ovf});
        wait_done(18);
    endtask

    // Watch the scan for 20 cycles: anode order, dwell time, segments and dp per digit
    task automatic disp_check(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] exp_s[4];
        int k, prev_k, run;
        bit first_run;
        exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2; exp_s[3] = s3;
        prev_k = -1; run = 0; first_run = 1'b1;
        @(posedge clk);
        repeat (20) begin
            @(negedge clk);
            case (an)
                4'b1110: k = 0;
                4'b1101: k = 1;
                4'b1011: k = 2;
                4'b0111: k = 3;
                default: k = -1;
            endcase
            if (k < 0) begin
                chk("an_onehot", 32'(an), 32'hE);
            end else begin
                chk($sformatf("seg_d%0d", k), 32'(seg), 32'(exp_s[k]));
                chk($sformatf("dp_d%0d", k), 32'(dp), 32'(k != 1));
                if (prev_k >= 0 && k != prev_k) begin
                    chk("an_order", 32'(k), 32'((prev_k + 1) % 4));
                    if (!first_run) chk("an_dwell", 32'(run), 32'd4);
                    first_run = 1'b0;
                    run = 0;
                end
                run++;
                prev_k = k;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        tm  = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_done", 32'(conv_done), 32'd0);

        // Forced conversion of Time=0 right after reset
        @(negedge clk);
        rst = 1'b0;
        sb.push_back({20'h00000, 1'b0});
        wait_done(18);
        disp_check(7'h40, 7'h40, 7'h7F, 7'h7F);

        apply(16'd1234, 20'h01234, 1'b0);
        disp_check(7'h19, 7'h30, 7'h24, 7'h79);

        apply(16'd9999, 20'h09999, 1'b0);
        apply(16'd10000, 20'h10000, 1'b1);
        disp_check(7'h40, 7'h40, 7'h40, 7'h40);
        apply(16'd42, 20'h00042, 1'b0);
        disp_check(7'h24, 7'h19, 7'h7F, 7'h7F);

        // Change during SHIFT: first result keeps 5, 6 follows on the next IDLE edge
        @(negedge clk);
        tm = 16'd5;
        sb.push_back({20'h00005, 1'b0});
        repeat (3) @(posedge clk);
        @(negedge clk);
        tm = 16'd6;
        sb.push_back({20'h00006, 1'b0});
        wait_done(15);
        wait_done(18);

        // Reset in the middle of SHIFT, from an overflowed state
        apply(16'd20000, 20'h20000, 1'b1);
        @(negedge clk);
        tm = 16'd777;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_dp", 32'(dp), 32'd1);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        chk("midrst_done", 32'(conv_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.push_back({20'h00777, 1'b0});
        wait_done(18);

        // Sweep: every value 0..299, a stride across the range, and the edges
        for (int v = 0; v < 300; v++) apply(16'(v), ref_bcd(v), 1'b0);
        for (int v = 1000; v < 65536; v += 997) apply(16'(v), ref_bcd(v), v > 9999);
        begin
            int edge_v[8] = '{9998, 9999, 10000, 10001, 59999, 60000, 65534, 65535};
            foreach (edge_v[i]) apply(16'(edge_v[i]), ref_bcd(edge_v[i]), edge_v[i] > 9999);
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
